fifo_scoreboard: RTL and testbench

- Self-checking scoreboard that sits beside a DUT FIFO in simulation and in on-chip BIST builds.
- Mirrors every DUT write into an internal reference FIFO and pops the expected word on every DUT read.
- Compares the popped word against the DUT's read data after a parametrised read latency.
- Reports mismatch, overflow and underflow per event, plus a sticky error flag, a saturating error counter and the model occupancy.

---
 rtl/fifo_scoreboard_if.sv | 36 +++
 rtl/fifo_scoreboard.sv | 153 +++++++++++++++
 tb/tb_fifo_scoreboard.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_scoreboard_if.sv
// fifo_scoreboard_if: DUT-side strobes/data plus the scoreboard's status outputs
// Signals: clr, wq, rq, wr_data, fo_data (master -> slave);
// level, exp_data, mismatch, overflow, underflow, error, err_sticky, err_cnt,
// first_idx, first_exp, first_act (slave -> master)
interface fifo_scoreboard_if #(
  parameter int DATA_W = 8,
  parameter int PTR_W  = 4,
  parameter int CNT_W  = 8
);
  logic                    clr;
  logic                    wq;
  logic                    rq;
  logic [DATA_W-1:0]       wr_data;
  logic [DATA_W-1:0]       fo_data;
  logic [PTR_W:0]          level;
  logic [DATA_W-1:0]       exp_data;
  logic                    mismatch;
  logic                    overflow;
  logic                    underflow;
  logic                    error;
  logic                    err_sticky;
  logic [CNT_W-1:0]        err_cnt;
  logic [PTR_W+CNT_W-1:0]  first_idx;
  logic [DATA_W-1:0]       first_exp;
  logic [DATA_W-1:0]       first_act;
  modport master (
    output clr, wq, rq, wr_data, fo_data,
    input  level, exp_data, mismatch, overflow, underflow, error, err_sticky, err_cnt,
           first_idx, first_exp, first_act
  );
  modport slave (
    input  clr, wq, rq, wr_data, fo_data,
    output level, exp_data, mismatch, overflow, underflow, error, err_sticky, err_cnt,
           first_idx, first_exp, first_act
  );
endinterface

// File: rtl/fifo_scoreboard.sv
// fifo_scoreboard: reference-FIFO checker mirroring a DUT FIFO's writes/reads
// Ports: clk, rst (async, active-high), sb (fifo_scoreboard_if.slave):
//   clr sync clear; wq/rq/wr_data DUT strobes; fo_data DUT read data RD_LAT after rq;
//   level model occupancy; exp_data expected word of the compare just made (0 if none);
//   mismatch/overflow/underflow/error registered pulses; err_sticky; err_cnt saturating;
//   first_idx/first_exp/first_act first-mismatch capture (macro SB_FIRST_ERR_CAPTURE_EN)
// Build option: define SB_FIRST_ERR_CAPTURE_EN to build the first-mismatch capture registers.
module fifo_scoreboard #(
  parameter int DATA_W      = 8,
  parameter int PTR_W       = 4,
  parameter int RD_LAT      = 1,
  parameter int CNT_W       = 8,
  parameter int HALT_ON_ERR = 0
) (
  input logic              clk,
  input logic              rst,
  fifo_scoreboard_if.slave sb
);
  localparam int DEPTH = 1 << PTR_W;
  localparam int PL    = RD_LAT > 0 ? RD_LAT : 1;
  typedef enum logic {RUN, FAULT} state_t;
  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      mem_q [DEPTH];
  logic [PTR_W:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, lvl;
  logic [PL-1:0]          pv_q, pv_d;
  logic [DATA_W-1:0]      pd_q [PL];
  logic [DATA_W-1:0]      pd_d [PL];
  logic [DATA_W-1:0]      head, cmp_exp, exp_q, exp_d;
  logic                   run, full, empty, push, pop, cmp_v, mis, ovf, unf;
  logic                   mis_q, ovf_q, unf_q, err_q, sticky_q, sticky_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W:0]         cnt_sum;
  logic [PTR_W+CNT_W-1:0] ridx_q, ridx_d;
  always_comb begin
    lvl     = wr_ptr_q - rd_ptr_q;
    full    = lvl == {1'b1, {PTR_W{1'b0}}};
    empty   = lvl == '0;
    // clr pre-empts this cycle's events so nothing is counted on the clearing edge
    run     = state_q == RUN && !sb.clr;
    head    = mem_q[rd_ptr_q[PTR_W-1:0]];
    // read is ordered before write: a read on an empty model never sees the same-cycle write
    pop     = run && sb.rq && !empty;
    push    = run && sb.wq && (!full || sb.rq);
    unf     = run && sb.rq && empty;
    ovf     = run && sb.wq && full && !sb.rq;
    cmp_v   = RD_LAT == 0 ? pop : pv_q[PL-1];
    cmp_exp = RD_LAT == 0 ? head : pd_q[PL-1];
    mis     = run && cmp_v && sb.fo_data != cmp_exp;
    pv_d    = pv_q;
    pd_d    = pd_q;
    if (state_q == RUN) begin
      pv_d[0] = pop;
      pd_d[0] = head;
      for (int i = 1; i < PL; i++) begin
        pv_d[i] = pv_q[i-1];
        pd_d[i] = pd_q[i-1];
      end
    end
    if (sb.clr) pv_d = '0;
    wr_ptr_d = sb.clr ? '0 : wr_ptr_q + (PTR_W+1)'(push);
    rd_ptr_d = sb.clr ? '0 : rd_ptr_q + (PTR_W+1)'(pop);
    ridx_d   = sb.clr ? '0 : ridx_q + (PTR_W+CNT_W)'(run && cmp_v);
    cnt_sum  = {1'b0, cnt_q} + (CNT_W+1)'({1'b0, mis} + {1'b0, ovf} + {1'b0, unf});
    cnt_d    = sb.clr ? '0 : cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    sticky_d = !sb.clr && (sticky_q || mis || ovf || unf);
    exp_d    = run && cmp_v ? cmp_exp : '0;
    state_d  = sb.clr ? RUN : (HALT_ON_ERR != 0 && (mis || ovf || unf)) ? FAULT : state_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pv_q     <= '0;
      for (int i = 0; i < PL; i++) pd_q[i] <= '0;
      ridx_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      exp_q    <= '0;
      mis_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pv_q     <= pv_d;
      for (int i = 0; i < PL; i++) pd_q[i] <= pd_d[i];
      ridx_q   <= ridx_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      exp_q    <= exp_d;
      mis_q    <= mis;
      ovf_q    <= ovf;
      unf_q    <= unf;
      err_q    <= mis || ovf || unf;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= sb.wr_data;
  end
  assign sb.level      = lvl;
  assign sb.exp_data   = exp_q;
  assign sb.mismatch   = mis_q;
  assign sb.overflow   = ovf_q;
  assign sb.underflow  = unf_q;
  assign sb.error      = err_q;
  assign sb.err_sticky = sticky_q;
  assign sb.err_cnt    = cnt_q;
`ifdef SB_FIRST_ERR_CAPTURE_EN
  logic                   cap_q, cap_d;
  logic [PTR_W+CNT_W-1:0] fidx_q, fidx_d;
  logic [DATA_W-1:0]      fexp_q, fexp_d, fact_q, fact_d;
  always_comb begin
    cap_d  = cap_q || mis;
    fidx_d = fidx_q;
    fexp_d = fexp_q;
    fact_d = fact_q;
    if (mis && !cap_q) begin
      fidx_d = ridx_q;
      fexp_d = cmp_exp;
      fact_d = sb.fo_data;
    end
    if (sb.clr) begin
      cap_d  = 1'b0;
      fidx_d = '0;
      fexp_d = '0;
      fact_d = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q  <= 1'b0;
      fidx_q <= '0;
      fexp_q <= '0;
      fact_q <= '0;
    end else begin
      cap_q  <= cap_d;
      fidx_q <= fidx_d;
      fexp_q <= fexp_d;
      fact_q <= fact_d;
    end
  end
  assign sb.first_idx = fidx_q;
  assign sb.first_exp = fexp_q;
  assign sb.first_act = fact_q;
`else
  assign sb.first_idx = '0;
  assign sb.first_exp = '0;
  assign sb.first_act = '0;
`endif
endmodule

// File: tb/tb_fifo_scoreboard.sv
// tb_fifo_scoreboard: randomized queue-model bench with decoupled scoreboard monitor
module tb_fifo_scoreboard;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 16;
  typedef struct {
    int mis, ovf, unf, err, exp, lvl, cnt, sticky, fidx, fexp, fact;
  } exp_t;
  typedef struct {
    int due;
    int d;
  } pend_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int pass = 0;
  int cyc = 0;
  int errs = 0;
  int sticky = 0;
  int ncmp = 0;
  int have_first = 0;
  int f_idx = 0, f_exp = 0, f_act = 0;
  int mq[$];
  pend_t pend[$];
  exp_t expq[$];
  exp_t me;
  fifo_scoreboard_if #(.DATA_W(8), .PTR_W(4), .CNT_W(8)) s();
  fifo_scoreboard_if #(.DATA_W(8), .PTR_W(4), .CNT_W(8)) h();
  fifo_scoreboard #(.DATA_W(8), .PTR_W(4), .RD_LAT(RD_LAT), .CNT_W(8), .HALT_ON_ERR(0))
    dut (.clk(clk), .rst(rst), .sb(s));
  fifo_scoreboard #(.DATA_W(8), .PTR_W(4), .RD_LAT(1), .CNT_W(8), .HALT_ON_ERR(1))
    hdut (.clk(clk), .rst(rst), .sb(h));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int x);
    total++;
    if (a == x) pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", n, a, x, $time);
  endtask
  task automatic flush();
    mq.delete();
    pend.delete();
    expq.delete();
    errs = 0;
    sticky = 0;
    ncmp = 0;
    have_first = 0;
  endtask
  task automatic step(input bit w, input bit r, input int d, input bit bad);
    exp_t e;
    pend_t p;
    int act;
    @(negedge clk);
    e = '{default: 0};
    act = $urandom_range(0, 255);
    e.unf = int'(r && mq.size() == 0);
    e.ovf = int'(w && mq.size() == DEPTH && !r);
    if (r && mq.size() > 0) begin
      p.due = cyc + RD_LAT;
      p.d = mq.pop_front();
      pend.push_back(p);
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      act = bad ? (p.d ^ 1) : p.d;
      e.exp = p.d;
      e.mis = int'(bad);
      if (bad && have_first == 0) begin
        have_first = 1;
        f_idx = ncmp;
        f_exp = p.d;
        f_act = act;
      end
      ncmp++;
    end
    if (w && mq.size() < DEPTH) mq.push_back(d & 8'hff);
    e.err = (e.mis | e.ovf | e.unf);
    errs = errs + e.mis + e.ovf + e.unf;
    if (errs > 255) errs = 255;
    if (e.err != 0) sticky = 1;
    e.lvl = mq.size();
    e.cnt = errs;
    e.sticky = sticky;
`ifdef SB_FIRST_ERR_CAPTURE_EN
    if (have_first != 0) begin
      e.fidx = f_idx % 4096;
      e.fexp = f_exp;
      e.fact = f_act;
    end
`endif
    expq.push_back(e);
    s.wq = w;
    s.rq = r;
    s.wr_data = d[7:0];
    s.fo_data = act[7:0];
    cyc++;
  endtask
  task automatic hstep(input bit w, input bit r, input int d, input int fo);
    @(negedge clk);
    h.wq = w;
    h.rq = r;
    h.wr_data = d[7:0];
    h.fo_data = fo[7:0];
    @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (expq.size() > 0) begin
      me = expq.pop_front();
      chk("mismatch", int'(s.mismatch), me.mis);
      chk("overflow", int'(s.overflow), me.ovf);
      chk("underflow", int'(s.underflow), me.unf);
      chk("error", int'(s.error), me.err);
      chk("exp_data", int'(s.exp_data), me.exp);
      chk("level", int'(s.level), me.lvl);
      chk("err_cnt", int'(s.err_cnt), me.cnt);
      chk("err_sticky", int'(s.err_sticky), me.sticky);
      chk("first_idx", int'(s.first_idx), me.fidx);
      chk("first_exp", int'(s.first_exp), me.fexp);
      chk("first_act", int'(s.first_act), me.fact);
    end
  end
  initial begin
    {s.clr, s.wq, s.rq, s.wr_data, s.fo_data} = '0;
    {h.clr, h.wq, h.rq, h.wr_data, h.fo_data} = '0;
    repeat (2) @(negedge clk);
    chk("rst_level", int'(s.level), 0);
    chk("rst_err_cnt", int'(s.err_cnt), 0);
    chk("rst_sticky", int'(s.err_sticky), 0);
    chk("rst_exp_data", int'(s.exp_data), 0);
    rst = 1'b0;
    step(1, 0, 'h11, 0);
    step(1, 0, 'h22, 0);
    step(1, 0, 'h33, 0);
    repeat (3) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 'hA5, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, $urandom_range(0, 255), 0);
    step(1, 0, 'h77, 0);
    step(1, 1, 'h78, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 'h5C, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      int ph;
      ph = (i / 100) % 2;
      step($urandom_range(0, 9) < (ph == 0 ? 7 : 3), $urandom_range(0, 9) < (ph == 0 ? 3 : 7),
           $urandom_range(0, 255), $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 4; i++) step(1, 0, $urandom_range(0, 255), 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    @(negedge clk);
    rst = 1'b1;
    s.wq = 1'b0;
    s.rq = 1'b0;
    s.fo_data = 8'h00;
    flush();
    #1;
    chk("mid_rst_mismatch", int'(s.mismatch), 0);
    chk("mid_rst_error", int'(s.error), 0);
    chk("mid_rst_level", int'(s.level), 0);
    chk("mid_rst_err_cnt", int'(s.err_cnt), 0);
    chk("mid_rst_sticky", int'(s.err_sticky), 0);
    chk("mid_rst_exp_data", int'(s.exp_data), 0);
    @(negedge clk);
    #1;
    chk("mid_rst_mismatch_hold", int'(s.mismatch), 0);
    rst = 1'b0;
    step(1, 0, 'h5A, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    @(negedge clk);
    chk("scoreboard_drained", expq.size(), 0);
    hstep(1, 0, 'hA5, 0);
    chk("halt_level1", int'(h.level), 1);
    hstep(0, 1, 0, 0);
    hstep(0, 0, 0, 'hA4);
    chk("halt_mismatch", int'(h.mismatch), 1);
    chk("halt_err_cnt", int'(h.err_cnt), 1);
    chk("halt_exp_data", int'(h.exp_data), 'hA5);
    for (int i = 0; i < 5; i++) begin
      hstep(1, 1, i, 'hFF);
      chk("fault_err_cnt", int'(h.err_cnt), 1);
      chk("fault_mismatch", int'(h.mismatch), 0);
      chk("fault_sticky", int'(h.err_sticky), 1);
      chk("fault_level", int'(h.level), 0);
    end
    @(negedge clk);
    h.clr = 1'b1;
    h.wq = 1'b0;
    h.rq = 1'b0;
    @(posedge clk);
    #1;
    chk("clr_level", int'(h.level), 0);
    chk("clr_sticky", int'(h.err_sticky), 0);
    chk("clr_err_cnt", int'(h.err_cnt), 0);
    @(negedge clk);
    h.clr = 1'b0;
    hstep(1, 0, 'h3C, 0);
    chk("resume_level", int'(h.level), 1);
    hstep(0, 1, 0, 0);
    hstep(0, 0, 0, 'h3C);
    chk("resume_mismatch", int'(h.mismatch), 0);
    chk("resume_err_cnt", int'(h.err_cnt), 0);
    hstep(0, 0, 0, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
